masked_serial_layer: RTL and testbench
======================================

Name: masked_serial_layer

Overview:
- Fully-connected layer computing OUTPUT_SIZE neurons from INPUT_SIZE inputs, one neuron at a time, on a single shared multiply-accumulate (MAC) unit.
- The accumulator is held as two arithmetic shares, refreshed every cycle with external randomness, so no intermediate partial sum appears in a register in the clear.
- Successor to the combinational one-shot layer, with:
  - generic sizes;
  - weights and biases fetched from external memory;
  - fixed-point scaling, saturation and optional ReLU;
  - a valid/ready result stream.
- Sits between the input/activation buffer and the next layer, or the argmax stage.

Parameters:
- INPUT_SIZE, 10, number of inputs per neuron (≥1).
- OUTPUT_SIZE, 10, number of neurons (≥1).
- WIDTH, 16, data width of inputs, weights, biases and outputs (signed two's complement).
- FRAC_BITS, 8, fractional bits of the fixed-point format.
- ACC_WIDTH, 2*WIDTH+8, accumulator share width.
- RELU_EN, 1, when 1, negative results are clamped to 0.

Ports:
- clk, in, 1, clock; all state changes on rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse; latches inputs and begins a layer pass (accepted in IDLE only).
- inputs_flat, in, INPUT_SIZE*WIDTH, input vector; element i is bits [i*WIDTH +: WIDTH].
- busy, out, 1, high from the cycle after an accepted start until the last result is accepted.
- w_addr, out, clog2(INPUT_SIZE*OUTPUT_SIZE), weight address = neuron*INPUT_SIZE + i.
- w_data, in, WIDTH, weight word; valid exactly 1 cycle after w_addr.
- b_addr, out, clog2(OUTPUT_SIZE), bias address = neuron.
- b_data, in, WIDTH, bias word; valid 1 cycle after b_addr.
- rnd, in, ACC_WIDTH, fresh random mask; sampled every MAC cycle.
- out_valid, out, 1, result available.
- out_ready, in, 1, downstream accepts the result.
- out_data, out, WIDTH, neuron result.
- out_idx, out, clog2(OUTPUT_SIZE), neuron index of out_data.
- done, out, 1, one-cycle pulse after the last result handshake.

Behaviour:
Reset (asynchronous, immediate):
- State is IDLE.
- busy, out_valid and done are 0.
- out_data, out_idx, w_addr and b_addr are 0.
- Shares, counters and the input latch are 0.

FSM states: IDLE, MAC, FINAL, OUT.

IDLE:
- On start, latch inputs_flat and set neuron=0, i=0.
- Clear both shares to 0; go to MAC.
- start is ignored in all other states.

MAC, lasting exactly INPUT_SIZE+1 cycles per neuron:
- Cycle k (0..INPUT_SIZE-1) drives w_addr = neuron*INPUT_SIZE + k.
- Cycle 0 also drives b_addr = neuron.
- Cycle k ≥ 1 forms p = sext(in[k-1]*w_data), a full 2*WIDTH signed product extended to ACC_WIDTH.
- Share update in the same cycle: s0 <= s0 + p + rnd, s1 <= s1 - rnd (both mod 2^ACC_WIDTH).
- b_data is captured in cycle 1.
- After cycle INPUT_SIZE, go to FINAL.

FINAL, 1 cycle:
- sum = s0 + s1.
- r = (sum >>> FRAC_BITS) + sext(bias).
- Saturate r to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- If RELU_EN and r < 0, r = 0.
- Register r into out_data and neuron into out_idx; set out_valid=1; go to OUT.
- Recombination exists only in this combinational path; shares are never written unmasked.

OUT:
- Hold out_data, out_idx and out_valid stable until out_valid && out_ready.
- On that handshake:
  - if neuron == OUTPUT_SIZE-1: clear out_valid, pulse done, clear busy, go to IDLE;
  - otherwise: increment neuron, clear shares and out_valid, go to MAC.

Timing:
- Latency from start to first out_valid = INPUT_SIZE+2 cycles.
- With out_ready tied high, each neuron takes INPUT_SIZE+3 cycles.

Boundary conditions:
- If out_ready is already high when out_valid rises, the handshake completes in that first OUT cycle.
- INPUT_SIZE=1 gives 2 MAC cycles.
- Accumulator shares wrap modulo 2^ACC_WIDTH by design; only the recombined sum is meaningful.
- ACC_WIDTH is sized so that the true sum never overflows for INPUT_SIZE ≤ 256.
- Arithmetic shift rounds toward −inf (truncation, no rounding).
- Reset asserted mid-pass aborts immediately; no done pulse; a new start is required afterwards.
- rnd is don't-care outside MAC; the result must be bit-identical for any rnd sequence.

Test Plan:
- Ones × halves: INPUT_SIZE=10, all inputs 0x0100, all weights 0x0080, bias 0, out_ready=1 → out_data=0x0500 for idx 0..9; done pulses once; total cycles = 10×13.
- Mask independence: same vectors run with rnd=0 and then with random rnd → identical out_data sequence.
- Saturation and ReLU: inputs 0x7FFF and weights 0x7FFF with bias 0 → 0x7FFF; weights 0x8000 with RELU_EN=1 → 0x0000; same with RELU_EN=0 → 0x8000.
- Bias and index: inputs 0, bias[n]=n*0x0100 → out_data = n<<8 with out_idx=n; w_addr and b_addr sequences match neuron*INPUT_SIZE+k and n.
- Backpressure: out_ready low for 5 cycles on neuron 3 → out_data and out_idx held stable, no MAC activity; resume gives the correct value; start pulsed while busy is ignored.
- Reset mid-pass: assert rst during neuron 4 MAC → all outputs 0 immediately; new start → full correct 10-result pass.

Source files
------------

// File: rtl/masked_serial_layer.sv
// masked_serial_layer: one fully-connected layer evaluated one neuron at a
// time on a single shared MAC unit. The running sum is kept as two
// arithmetic shares that are re-masked with fresh randomness every cycle.
// The sum is recombined only in the combinational output path.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, inputs_flat start pulse (honoured in IDLE only), input vector
//   busy               high while a layer pass is in progress
//   w_addr, w_data     weight fetch (data returns one cycle after address)
//   b_addr, b_data     bias fetch (data returns one cycle after address)
//   rnd                fresh mask word, consumed on every MAC cycle
//   out_valid/ready    result stream handshake
//   out_data, out_idx  neuron result and its index
//   done               one-cycle pulse after the last result handshake
module masked_serial_layer #(
    parameter int INPUT_SIZE  = 10,
    parameter int OUTPUT_SIZE = 10,
    parameter int WIDTH       = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 2*WIDTH+8,
    parameter bit RELU_EN     = 1'b1,
    localparam int WA = (INPUT_SIZE*OUTPUT_SIZE > 1) ?
                        $clog2(INPUT_SIZE*OUTPUT_SIZE) : 1,
    localparam int NW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [INPUT_SIZE*WIDTH-1:0] inputs_flat,
    output logic                        busy,
    output logic [WA-1:0]               w_addr,
    input  logic [WIDTH-1:0]            w_data,
    output logic [NW-1:0]               b_addr,
    input  logic [WIDTH-1:0]            b_data,
    input  logic [ACC_WIDTH-1:0]        rnd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [NW-1:0]               out_idx,
    output logic                        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam int KW = $clog2(INPUT_SIZE+1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [1:0]                  state;
    logic [KW-1:0]               k;
    logic [NW-1:0]               neuron;
    logic [WA-1:0]               w_base;
    logic [INPUT_SIZE*WIDTH-1:0] in_lat;
    logic [INPUT_SIZE*WIDTH-1:0] in_rot;
    logic [ACC_WIDTH-1:0]        s0;
    logic [ACC_WIDTH-1:0]        s1;
    logic [WIDTH-1:0]            bias;

    logic signed [2*WIDTH-1:0]   prod;
    logic [ACC_WIDTH-1:0]        p;
    logic [ACC_WIDTH-1:0]        sum;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic signed [ACC_WIDTH-1:0] r_full;
    logic [WIDTH-1:0]            r_sat;
    logic                        k_last;

    // The input latch rotates one element per product, so the element
    // needed next is always in the low slot; after INPUT_SIZE products it
    // is back in its original order for the next neuron.
    generate
        if (INPUT_SIZE > 1) begin : g_rot
            assign in_rot = {in_lat[WIDTH-1:0],
                             in_lat[INPUT_SIZE*WIDTH-1:WIDTH]};
        end else begin : g_norot
            assign in_rot = in_lat;
        end
    endgenerate

    assign k_last = (k == KW'(INPUT_SIZE));

    assign prod = $signed(in_lat[WIDTH-1:0]) * $signed(w_data);
    assign p    = {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};

    // Only place the two shares are ever combined.
    assign sum    = s0 + s1;
    assign scaled = $signed(sum) >>> FRAC_BITS;
    assign r_full = scaled + {{(ACC_WIDTH-WIDTH){bias[WIDTH-1]}}, bias};

    always_comb begin
        r_sat = r_full[WIDTH-1:0];
        if (r_full > SAT_HI) begin
            r_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (r_full < SAT_LO) begin
            r_sat = {1'b1, {(WIDTH-1){1'b0}}};
        end
        if (RELU_EN && r_sat[WIDTH-1]) begin
            r_sat = '0;
        end
    end

    assign w_addr = (state == S_MAC && !k_last) ? w_base + WA'(k) : '0;
    assign b_addr = neuron;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            neuron    <= '0;
            w_base    <= '0;
            in_lat    <= '0;
            s0        <= '0;
            s1        <= '0;
            bias      <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        in_lat <= inputs_flat;
                        neuron <= '0;
                        w_base <= '0;
                        k      <= '0;
                        s0     <= '0;
                        s1     <= '0;
                        busy   <= 1'b1;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Cycle 0 only issues the first fetch; products
                    // start once the first weight has returned.
                    if (k != '0) begin
                        s0     <= s0 + p + rnd;
                        s1     <= s1 - rnd;
                        in_lat <= in_rot;
                    end
                    if (k == KW'(1)) begin
                        bias <= b_data;
                    end
                    if (k_last) begin
                        k     <= '0;
                        state <= S_FINAL;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_FINAL: begin
                    out_data  <= r_sat;
                    out_idx   <= neuron;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (neuron == NW'(OUTPUT_SIZE-1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            neuron <= neuron + 1'b1;
                            w_base <= w_base + WA'(INPUT_SIZE);
                            s0     <= '0;
                            s1     <= '0;
                            state  <= S_MAC;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_serial_layer.sv
// Directed bench for masked_serial_layer: two instances (ReLU on/off) share
// a registered weight/bias memory model and a stream of random masks.
module tb_masked_serial_layer;

    localparam int IN = 10;
    localparam int ON = 10;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [IN*W-1:0] inputs_flat = '0;
    logic [39:0]   rnd = '0;
    logic [15:0]   w_data;
    logic [15:0]   b_data;

    logic          busy, out_valid, done;
    logic [6:0]    w_addr;
    logic [3:0]    b_addr;
    logic [15:0]   out_data;
    logic [3:0]    out_idx;

    logic          busy_n, out_valid_n, done_n;
    logic [6:0]    w_addr_n;
    logic [3:0]    b_addr_n;
    logic [15:0]   out_data_n;
    logic [3:0]    out_idx_n;

    logic [15:0]   wmem [0:127];
    logic [15:0]   bmem [0:15];

    int checks = 0;
    int fails  = 0;
    bit rnd_on = 1'b0;

    int res [16];
    int resn [16];
    int ridx [16];
    int nres, ndone, done_cyc, first_vcyc;

    masked_serial_layer #(
        .INPUT_SIZE(IN), .OUTPUT_SIZE(ON), .WIDTH(W),
        .FRAC_BITS(8), .ACC_WIDTH(40), .RELU_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .inputs_flat(inputs_flat),
        .busy(busy), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .done(done)
    );

    masked_serial_layer #(
        .INPUT_SIZE(IN), .OUTPUT_SIZE(ON), .WIDTH(W),
        .FRAC_BITS(8), .ACC_WIDTH(40), .RELU_EN(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .start(start), .inputs_flat(inputs_flat),
        .busy(busy_n), .w_addr(w_addr_n), .w_data(w_data),
        .b_addr(b_addr_n), .b_data(b_data), .rnd(rnd),
        .out_valid(out_valid_n), .out_ready(out_ready),
        .out_data(out_data_n), .out_idx(out_idx_n), .done(done_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data <= wmem[w_addr];
        b_data <= bmem[b_addr];
    end

    initial begin
        logic [63:0] r64;
        forever begin
            @(negedge clk);
            if (rnd_on) begin
                r64 = {$urandom(), $urandom()};
                rnd = r64[39:0];
            end else begin
                rnd = '0;
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_val(input int mode, input int n);
        case (mode)
            0: exp_val = 32'h0500;
            1: exp_val = 32'h7FFF;
            2: exp_val = 32'h0000;
            3: exp_val = n << 8;
            default: exp_val = 806*n + 330;
        endcase
    endfunction

    task automatic load(input int mode);
        for (int i = 0; i < IN; i++) begin
            case (mode)
                0: inputs_flat[i*W +: W] = 16'h0100;
                1, 2: inputs_flat[i*W +: W] = 16'h7FFF;
                3: inputs_flat[i*W +: W] = 16'h0000;
                default: inputs_flat[i*W +: W] = 16'((i+1) << 8);
            endcase
        end
        for (int a = 0; a < 128; a++) begin
            case (mode)
                0: wmem[a] = 16'h0080;
                1: wmem[a] = 16'h7FFF;
                2: wmem[a] = 16'h8000;
                default: wmem[a] = 16'(a);
            endcase
        end
        for (int n = 0; n < 16; n++) begin
            bmem[n] = (mode >= 3) ? 16'(n << 8) : 16'h0000;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input int stall_idx, input int stall_exp);
        int cyc;
        bit stalled;
        logic [IN*W-1:0] saved_in;
        pulse_start();
        saved_in = inputs_flat;
        inputs_flat = ~inputs_flat;
        check("busy_after_start", busy, 1);
        cyc = 0; nres = 0; ndone = 0;
        done_cyc = -1; first_vcyc = -1; stalled = 1'b0;
        while (ndone == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (out_valid && first_vcyc < 0) first_vcyc = cyc;
            if (out_valid && int'(out_idx) == stall_idx && !stalled) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    start = (j == 1);
                    @(negedge clk);
                    cyc++;
                    check("hold_data", out_data, stall_exp);
                    check("hold_idx", out_idx, stall_idx);
                    check("hold_valid", out_valid, 1);
                end
                start = 1'b0;
                out_ready = 1'b1;
            end
            if (out_valid && out_ready && nres < 16) begin
                res[nres]  = int'(out_data);
                resn[nres] = int'(out_data_n);
                ridx[nres] = int'(out_idx);
                nres++;
            end
        end
        check("done_seen", ndone, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_cleared", busy, 0);
        inputs_flat = saved_in;
    endtask

    task automatic check_results(input int mode);
        check("result_count", nres, ON);
        for (int n = 0; n < ON && n < nres; n++) begin
            check($sformatf("data_m%0d_n%0d", mode, n), res[n],
                  exp_val(mode, n));
            check($sformatf("idx_m%0d_n%0d", mode, n), ridx[n], n);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_waddr", w_addr, 0);
        check("rst_baddr", b_addr, 0);
        rst = 1'b0;

        load(0);
        run_pass(-1, 0);
        check_results(0);
        check("first_latency", first_vcyc, IN + 2);
        check("pass_cycles", done_cyc, ON * (IN + 3));

        rnd_on = 1'b1;
        run_pass(-1, 0);
        check_results(0);
        check("pass_cycles_masked", done_cyc, ON * (IN + 3));

        load(1);
        run_pass(-1, 0);
        check_results(1);
        check("sat_hi_norelu", resn[0], 32'h7FFF);

        load(2);
        run_pass(-1, 0);
        check_results(2);
        for (int n = 0; n < ON; n++) begin
            check($sformatf("sat_lo_norelu_n%0d", n), resn[n], 32'h8000);
        end

        load(3);
        run_pass(-1, 0);
        check_results(3);

        load(4);
        run_pass(3, exp_val(4, 3));
        check_results(4);

        pulse_start();
        repeat (57) @(negedge clk);
        check("pre_rst_data", out_data, exp_val(4, 3));
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_idx", out_idx, 0);
        check("mid_rst_waddr", w_addr, 0);
        check("mid_rst_baddr", b_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_pass(-1, 0);
        check_results(4);
        check("post_rst_cycles", done_cyc, ON * (IN + 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
